// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller beside decode.
//
// Tracks the destinations of the instructions in EX and MEM. It compares
// them with the decode-stage source registers and drives the stall and
// bubble controls for the fetch/decode pipeline registers. It also handles
// taken-branch flushes and the halt drain sequence, and keeps a saturating
// count of data-stall cycles.
//
// Parameters
//   FORWARD      1: EX/MEM forwarding present, stall only on load-use
//                0: no forwarding, stall on any EX or MEM destination match
//   DRAIN_CYCLES cycles spent draining after a halt leaves decode (1..7)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   instValid                    decode holds a real instruction
//   r1Num/r1Used, r2Num/r2Used   decode source registers and their use flags
//   regWriteNum_id/regWriteEN_id decode destination register and write enable
//   memRead_id, halt_id          decode instruction is a load / a halt
//   branchTaken                  EX resolved a taken branch this cycle
//   pcHold                       hold PC and IF/ID (combinational)
//   idexBubble                   load a nop into ID/EX (combinational)
//   ifidFlush                    replace IF/ID with a nop (combinational)
//   haltDone                     pipeline drained after halt, sticky until rst
//   stallCount                   saturating count of data-stall cycles
module hazard_ctrl #(
  parameter int unsigned FORWARD      = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instValid,
  input  logic [2:0]  r1Num,
  input  logic [2:0]  r2Num,
  input  logic        r1Used,
  input  logic        r2Used,
  input  logic [2:0]  regWriteNum_id,
  input  logic        regWriteEN_id,
  input  logic        memRead_id,
  input  logic        halt_id,
  input  logic        branchTaken,
  output logic        pcHold,
  output logic        idexBubble,
  output logic        ifidFlush,
  output logic        haltDone,
  output logic [15:0] stallCount
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic        halt_done_q, halt_done_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Scoreboard. The WB entry and the MEM load flag are not stored: the
  // register file bypasses WB write data to the read ports, so WB can never
  // cause a hazard, and MEM only matters without forwarding, where the load
  // flag is irrelevant.
  logic        ex_v_q, ex_v_d;
  logic [2:0]  ex_dest_q, ex_dest_d;
  logic        ex_ld_q, ex_ld_d;
  logic        mem_v_q, mem_v_d;
  logic [2:0]  mem_dest_q, mem_dest_d;

  logic in_run;
  logic ex_hit;
  logic mem_hit;
  logic raw_hit;
  logic data_stall;
  logic issue;

  always_comb begin
    in_run  = (state_q == ST_RUN);
    ex_hit  = ex_v_q & ((r1Used & (r1Num == ex_dest_q)) |
                        (r2Used & (r2Num == ex_dest_q)));
    mem_hit = mem_v_q & ((r1Used & (r1Num == mem_dest_q)) |
                         (r2Used & (r2Num == mem_dest_q)));
    raw_hit = (FORWARD != 0) ? (ex_hit & ex_ld_q) : (ex_hit | mem_hit);
    data_stall = in_run & instValid & ~branchTaken & raw_hit;
    // Decode instruction advances into EX only when nothing holds or kills it.
    issue = in_run & ~data_stall & ~branchTaken;
  end

  always_comb begin
    pcHold     = 1'b0;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    if (!in_run) begin
      pcHold     = 1'b1;
      idexBubble = 1'b1;
    end else if (branchTaken) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (data_stall) begin
      pcHold     = 1'b1;
      idexBubble = 1'b1;
    end
  end

  always_comb begin
    // A halt passes through EX as a non-writing entry.
    ex_v_d    = issue & instValid & regWriteEN_id & ~halt_id;
    ex_dest_d = issue ? regWriteNum_id : '0;
    ex_ld_d   = issue & memRead_id;
    mem_v_d    = ex_v_q;
    mem_dest_d = ex_dest_q;

    stall_cnt_d = stall_cnt_q;
    if (data_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halt_done_d = halt_done_q;
    case (state_q)
      ST_RUN: begin
        if (issue && instValid && halt_id) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d     = ST_HALTED;
          halt_done_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
        end
      end
      ST_HALTED: begin
        halt_done_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halt_done_q <= 1'b0;
      stall_cnt_q <= '0;
      ex_v_q      <= 1'b0;
      ex_dest_q   <= '0;
      ex_ld_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_dest_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_done_q <= halt_done_d;
      stall_cnt_q <= stall_cnt_d;
      ex_v_q      <= ex_v_d;
      ex_dest_q   <= ex_dest_d;
      ex_ld_q     <= ex_ld_d;
      mem_v_q     <= mem_v_d;
      mem_dest_q  <= mem_dest_d;
    end
  end

  assign haltDone   = halt_done_q;
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. Two instances share one stimulus stream:
// index 0 has forwarding with a 3-cycle drain, index 1 has no forwarding
// with a 5-cycle drain. A behavioural model tracks the producers of the
// last three issued instructions as a history list.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        instValid, r1Used, r2Used, regWriteEN_id, memRead_id;
  logic        halt_id, branchTaken;
  logic [2:0]  r1Num, r2Num, regWriteNum_id;

  logic        f_pc, f_bub, f_fl, f_done;
  logic [15:0] f_cnt;
  logic        n_pc, n_bub, n_fl, n_done;
  logic [15:0] n_cnt;

  hazard_ctrl #(.FORWARD(1), .DRAIN_CYCLES(3)) u_fwd (
    .clk(clk), .rst(rst), .instValid(instValid),
    .r1Num(r1Num), .r2Num(r2Num), .r1Used(r1Used), .r2Used(r2Used),
    .regWriteNum_id(regWriteNum_id), .regWriteEN_id(regWriteEN_id),
    .memRead_id(memRead_id), .halt_id(halt_id), .branchTaken(branchTaken),
    .pcHold(f_pc), .idexBubble(f_bub), .ifidFlush(f_fl),
    .haltDone(f_done), .stallCount(f_cnt)
  );

  hazard_ctrl #(.FORWARD(0), .DRAIN_CYCLES(5)) u_nofwd (
    .clk(clk), .rst(rst), .instValid(instValid),
    .r1Num(r1Num), .r2Num(r2Num), .r1Used(r1Used), .r2Used(r2Used),
    .regWriteNum_id(regWriteNum_id), .regWriteEN_id(regWriteEN_id),
    .memRead_id(memRead_id), .halt_id(halt_id), .branchTaken(branchTaken),
    .pcHold(n_pc), .idexBubble(n_bub), .ifidFlush(n_fl),
    .haltDone(n_done), .stallCount(n_cnt)
  );

  // {pcHold, idexBubble, ifidFlush, haltDone, stallCount}
  logic [19:0] obs [2];
  assign obs[0] = {f_pc, f_bub, f_fl, f_done, f_cnt};
  assign obs[1] = {n_pc, n_bub, n_fl, n_done, n_cnt};

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit         v;
    logic [2:0] dest;
    bit         ld;
  } slot_t;

  slot_t m_hist [2][3];      // [dut][age]: age 0 issued last cycle
  int    m_mode  [2] = '{0, 0}; // 0 running, 1 draining, 2 halted
  int    m_spent [2] = '{0, 0};
  int    m_cnt   [2] = '{0, 0};
  bit    m_done  [2] = '{0, 0};

  function automatic int m_drain(int k);
    return (k == 0) ? 3 : 5;
  endfunction

  function automatic bit m_reads(slot_t s);
    return s.v && ((r1Used && (r1Num == s.dest)) || (r2Used && (r2Num == s.dest)));
  endfunction

  function automatic bit m_stall(int k);
    if (m_mode[k] != 0 || !instValid || branchTaken) return 1'b0;
    if (k == 0) return m_reads(m_hist[k][0]) && m_hist[k][0].ld;
    return m_reads(m_hist[k][0]) || m_reads(m_hist[k][1]);
  endfunction

  function automatic logic [19:0] m_out(int k);
    logic [2:0] ctl;
    if (m_mode[k] != 0)      ctl = 3'b110;
    else if (branchTaken)    ctl = 3'b011;
    else if (m_stall(k))     ctl = 3'b110;
    else                     ctl = 3'b000;
    return {ctl, m_done[k], 16'(m_cnt[k])};
  endfunction

  task automatic m_step();
    bit    st;
    bit    iss;
    slot_t nw;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int j = 0; j < 3; j++) m_hist[k][j] = '{v: 1'b0, dest: 3'd0, ld: 1'b0};
        m_mode[k] = 0; m_spent[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end else begin
        st  = m_stall(k);
        iss = (m_mode[k] == 0) && !st && !branchTaken;
        nw.v    = iss && instValid && regWriteEN_id && !halt_id;
        nw.dest = regWriteNum_id;
        nw.ld   = iss && memRead_id;
        if (st && m_cnt[k] < 65535) m_cnt[k]++;
        if (m_mode[k] == 0 && iss && instValid && halt_id) begin
          m_mode[k] = 1; m_spent[k] = 0;
        end else if (m_mode[k] == 1) begin
          m_spent[k]++;
          if (m_spent[k] == m_drain(k)) begin
            m_mode[k] = 2; m_done[k] = 1'b1;
          end
        end
        m_hist[k][2] = m_hist[k][1];
        m_hist[k][1] = m_hist[k][0];
        m_hist[k][0] = nw;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic advance();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit u1, input logic [2:0] a1,
                       input bit u2, input logic [2:0] a2, input bit we,
                       input logic [2:0] wd, input bit ld, input bit hl,
                       input bit br);
    instValid = v; r1Used = u1; r1Num = a1; r2Used = u2; r2Num = a2;
    regWriteEN_id = we; regWriteNum_id = wd; memRead_id = ld;
    halt_id = hl; branchTaken = br;
  endtask

  task automatic idle();
    drive(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
  endtask

  task automatic flush();
    rst = 1'b1;
    idle();
    advance();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    advance();
    advance();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 20'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h expected %h", k, obs[k], 20'h0);
      end
      n_checks++;
      if (obs[k] !== m_out(k)) begin
        n_fail++;
        $display("FAIL reset_model dut%0d: got %h expected %h", k, obs[k], m_out(k));
      end
    end
  endtask

  task automatic test_load_use();
    flush();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 1, 0, 0); // load r3
        1, 2:    drive(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0, 0); // reads r3
        default: idle();
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m_out(k)) begin
          n_fail++;
          $display("FAIL load_use c%0d dut%0d: got %h expected %h", c, k, obs[k], m_out(k));
        end
      end
      if (c == 1 || c == 2) begin
        n_checks++;
        if (obs[0][19:18] !== ((c == 1) ? 2'b11 : 2'b00)) begin
          n_fail++;
          $display("FAIL load_use_hold c%0d: got %b expected %b", c, obs[0][19:18],
                   (c == 1) ? 2'b11 : 2'b00);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (obs[0][15:0] !== 16'd1) begin
          n_fail++;
          $display("FAIL load_use_count: got %0d expected 1", obs[0][15:0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_raw_nonload();
    flush();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:          drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0, 0, 0); // add -> r2
        1, 2, 3:    drive(1, 0, 3'd0, 1, 3'd2, 0, 3'd0, 0, 0, 0); // reads r2
        default:    idle();
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m_out(k)) begin
          n_fail++;
          $display("FAIL raw c%0d dut%0d: got %h expected %h", c, k, obs[k], m_out(k));
        end
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (obs[1][19] !== ((c <= 2) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL raw_nofwd_hold c%0d: got %b expected %b", c, obs[1][19], (c <= 2));
        end
      end
      if (c == 4) begin
        n_checks++;
        if ({obs[0][15:0], obs[1][15:0]} !== {16'd0, 16'd2}) begin
          n_fail++;
          $display("FAIL raw_counts: got %0d/%0d expected 0/2", obs[0][15:0], obs[1][15:0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_wb_bypass();
    flush();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 0, 0, 0); // writes r5
        1:       drive(1, 1, 3'd1, 0, 3'd0, 1, 3'd6, 0, 0, 0); // independent
        2:       drive(1, 0, 3'd0, 1, 3'd2, 1, 3'd7, 0, 0, 0); // independent
        3:       drive(1, 0, 3'd0, 1, 3'd5, 0, 3'd0, 0, 0, 0); // reads r5 (WB)
        default: idle();
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m_out(k)) begin
          n_fail++;
          $display("FAIL wb_bypass c%0d dut%0d: got %h expected %h", c, k, obs[k], m_out(k));
        end
      end
      n_checks++;
      if (obs[1][19] !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_bypass_hold c%0d: got %b expected 0", c, obs[1][19]);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    flush();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0:       drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 1, 0, 0); // load r4
        1:       drive(1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 0, 0, 1); // reader + branch
        2:       drive(1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 1); // halt + branch
        default: idle();
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m_out(k)) begin
          n_fail++;
          $display("FAIL branch c%0d dut%0d: got %h expected %h", c, k, obs[k], m_out(k));
        end
        if (c == 1 || c == 2) begin
          n_checks++;
          if (obs[k][19:17] !== 3'b011) begin
            n_fail++;
            $display("FAIL branch_ctl c%0d dut%0d: got %b expected 011", c, k, obs[k][19:17]);
          end
        end
        if (c == 6) begin
          n_checks++;
          if (obs[k] !== 20'h0) begin
            n_fail++;
            $display("FAIL branch_after dut%0d: got %h expected 00000", k, obs[k]);
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_halt_drain();
    flush();
    for (int c = 0; c < 22; c++) begin
      rst = (c == 20);
      if (c == 10) drive(1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0);
      else if (c > 10 && c < 20)
        drive(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
              1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)),
              3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)));
      else idle();
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m_out(k)) begin
          n_fail++;
          $display("FAIL halt c%0d dut%0d: got %h expected %h", c, k, obs[k], m_out(k));
        end
      end
      if (c >= 11 && c <= 20) begin
        n_checks++;
        if ({obs[0][19:16], obs[1][16]} !== {3'b110, (c >= 14), (c >= 16)}) begin
          n_fail++;
          $display("FAIL halt_seq c%0d: got %b/%b expected %b/%b", c, obs[0][19:16],
                   obs[1][16], {3'b110, (c >= 14)}, (c >= 16));
        end
      end
      if (c == 21) begin
        n_checks++;
        if ({obs[0][19:16], obs[1][19:16]} !== 8'h00) begin
          n_fail++;
          $display("FAIL halt_reset: got %b/%b expected 0000/0000", obs[0][19:16], obs[1][19:16]);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    flush();
    for (int c = 0; c < 6; c++) begin
      rst = (c == 2);
      case (c)
        0:       drive(1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0); // halt
        3:       drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 1, 0, 0); // load r1
        4:       drive(1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 0, 0, 0); // reads r1
        default: idle();
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m_out(k)) begin
          n_fail++;
          $display("FAIL mid_drain c%0d dut%0d: got %h expected %h", c, k, obs[k], m_out(k));
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({obs[0][19:16], obs[1][19:16]} !== 8'h00) begin
          n_fail++;
          $display("FAIL mid_drain_run: got %b/%b expected 0000/0000", obs[0][19:16], obs[1][19:16]);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    flush();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(59) == 0);
      drive(($urandom_range(3) != 0), 1'($urandom_range(1)), 3'($urandom_range(3)),
            1'($urandom_range(1)), 3'($urandom_range(3)), 1'($urandom_range(1)),
            3'($urandom_range(3)), 1'($urandom_range(1)), ($urandom_range(24) == 0),
            ($urandom_range(7) == 0));
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m_out(k)) begin
          n_fail++;
          $display("FAIL random c%0d dut%0d: got %h expected %h", c, k, obs[k], m_out(k));
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    int errs;
    errs = 0;
    flush();
    // Without forwarding each group gives two stalls: load r1, then a reader
    // of r1 held while r1 sits in EX and then in MEM.
    for (int g = 0; g < 32770; g++) begin
      for (int p = 0; p < 3; p++) begin
        if (p == 0) drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 1, 0, 0);
        else        drive(1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        #1;
        for (int k = 0; k < 2; k++) begin
          n_checks++;
          if (obs[k] !== m_out(k)) begin
            n_fail++;
            errs++;
            if (errs <= 10)
              $display("FAIL saturation g%0d p%0d dut%0d: got %h expected %h",
                       g, p, k, obs[k], m_out(k));
          end
        end
        advance();
      end
    end
    idle();
    #1;
    n_checks++;
    if (obs[1][15:0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturation_hold: got %h expected ffff", obs[1][15:0]);
    end
    n_checks++;
    if (obs[0][15:0] !== 16'd32770) begin
      n_fail++;
      $display("FAIL saturation_fwd_count: got %0d expected 32770", obs[0][15:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_raw_nonload();
    test_wb_bypass();
    test_branch();
    test_halt_drain();
    test_reset_mid_drain();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller that sits beside the decode stage.
- Keeps a shadow scoreboard of the destination registers of instructions in EX, MEM and WB. Compares it against the decode-stage source register numbers and raises stall and bubble controls for the fetch/decode pipeline registers.
- Also handles branch-taken flushes and the halt drain sequence, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- FORWARD, 1: 1 = EX/MEM forwarding exists, so stall only on load-use; 0 = no forwarding, so stall on any EX or MEM destination match.
- DRAIN_CYCLES, 3: cycles spent in DRAIN after a halt leaves decode, before haltDone asserts. Legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instValid  in  1  decode stage holds a real (non-nop) instruction
- r1Num  in  3  decode source register 1 (instr[10:8])
- r2Num  in  3  decode source register 2 (instr[7:5])
- r1Used  in  1  decode instruction reads r1Num
- r2Used  in  1  decode instruction reads r2Num
- regWriteNum_id  in  3  decode destination register
- regWriteEN_id  in  1  decode instruction writes the register file
- memRead_id  in  1  decode instruction is a load
- halt_id  in  1  decode instruction is a halt
- branchTaken  in  1  EX resolved a taken branch or jump this cycle
- pcHold  out  1  hold PC and the IF/ID register
- idexBubble  out  1  load a nop into ID/EX instead of the decode outputs
- ifidFlush  out  1  replace IF/ID contents with a nop
- haltDone  out  1  pipeline drained after a halt; sticky until rst
- stallCount  out  16  saturating count of data-stall cycles

Behaviour:
- Scoreboard: three entries, EX, MEM and WB. Each entry is {v, dest[2:0], ld}.
- Reset: all entries are cleared to v=0; state = RUN; stallCount = 0; haltDone = 0.
- Reset outputs: pcHold = 0, idexBubble = 0, ifidFlush = 0.
- Matching:
  - matchX(e) = e.v & ((r1Used & r1Num==e.dest) | (r2Used & r2Num==e.dest)).
  - R0 is an ordinary register; there is no zero-register exception.
  - WB is never a hazard, because the register file bypasses write data to the read ports in the same cycle.
- dataStall is asserted when state==RUN, instValid=1 and branchTaken=0, and one of the following holds:
  - FORWARD=1: matchX(EX) & EX.ld.
  - FORWARD=0: matchX(EX) | matchX(MEM).
- Every cycle, MEM is copied to WB and EX is copied to MEM.
- EX load rule:
  - EX <= {instValid & regWriteEN_id, regWriteNum_id, memRead_id} only when state==RUN, dataStall=0 and branchTaken=0.
  - Otherwise EX <= 0 (bubble).
- branchTaken (highest priority below rst):
  - Combinational outputs: ifidFlush=1, idexBubble=1, pcHold=0.
  - The decode instruction is killed: a halt in decode is ignored, and no stall is counted.
- dataStall:
  - Combinational outputs: pcHold=1, idexBubble=1, ifidFlush=0.
  - stallCount increments by 1 per stall cycle and saturates at 16'hFFFF.
- FSM states:
  - RUN: on halt_id & instValid & dataStall=0 & branchTaken=0, go to DRAIN and load drainCnt = DRAIN_CYCLES−1. The halt itself enters EX as a non-writing entry.
  - DRAIN: pcHold=1, idexBubble=1, ifidFlush=0. Decode inputs are ignored and branchTaken is ignored. drainCnt decrements each cycle; at 0, go to HALTED.
  - HALTED: haltDone=1 (registered, first asserted on the cycle after the last DRAIN cycle), pcHold=1, idexBubble=1. Stays here until rst.
- Halt with a hazard: a halt in decode that coincides with dataStall waits, and enters DRAIN on the first non-stall cycle.
- Latency: pcHold, idexBubble and ifidFlush are combinational from the inputs and the current state. Scoreboard, FSM and counter update on the rising edge of clk.
- Reset mid-drain returns to RUN with an empty scoreboard on the next edge.
- instValid=0: no hazard is raised, and a bubble enters EX.

Test Plan:
- Load-use, FORWARD=1: cycle 0 decode r3 ← load (memRead_id=1); cycle 1 decode reads r3 in r1Num → cycle 1 pcHold=1 and idexBubble=1; cycle 2 no stall; stallCount=1.
- Non-load RAW, FORWARD=1: ADD writes r2, then the next instruction reads r2 → no stall. With FORWARD=0 → pcHold=1 for 2 cycles (EX then MEM match), stallCount=2.
- WB bypass, FORWARD=0: writer of r5 followed by two independent instructions, then a reader of r5 → no stall.
- Branch flush over a hazard: load r4, then reader of r4 in decode with branchTaken=1 → ifidFlush=1, idexBubble=1, pcHold=0, stallCount unchanged.
- Halt drain, DRAIN_CYCLES=3: halt decoded at cycle 10 → pcHold=1 for cycles 11–13 and onwards, haltDone=1 from cycle 14 and stays 1. Assert rst at cycle 20 → cycle 21 state RUN, haltDone=0, pcHold=0.
- Saturation: preload via 65 540 consecutive load-use stalls → stallCount holds at 16'hFFFF.
